arbitro_mux6: RTL and testbench

- Round-robin arbiter that shares the 6-input selector mux (mux6_1) among six requesters.
- Grants the mux to one requester at a time and drives the mux's sparse 4-bit selector code from the grant.
- Sits between the requesting units and mux6_1; the requesters see a one-hot grant, and the mux sees `seletor`.

---
 rtl/arbitro_mux6.sv | 173 +++++++++++++++++
 tb/tb_arbitro_mux6.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux6.sv
// arbitro_mux6 -- round-robin arbiter sharing the mux6_1 selector among six
// requesters.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   requisicao  [5:0] request vector, bit i = requester i wants the mux
//   concessao   [5:0] registered one-hot grant, zero when idle
//   seletor     [3:0] registered sparse selector code for mux6_1
//   valido      registered, 1 while a grant is active
//
// Parameter:
//   MAX_POSSE   consecutive cycles a holder may keep the grant while someone
//               else waits (0 = unlimited, 0..255)
//
// Optional build macro:
//   ARBITRO_PRIORIDADE_FIXA_EN  fixed priority (lowest index wins) instead of
//                               round-robin; the rotation pointer is dropped.
module arbitro_mux6 #(
    parameter int unsigned MAX_POSSE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] requisicao,
    output logic [5:0] concessao,
    output logic [3:0] seletor,
    output logic       valido
);

    typedef enum logic {OCIOSO, POSSE} estado_t;

    // Saturation value of the posse counter; unused when MAX_POSSE == 0.
    localparam logic [7:0] LIMITE = (MAX_POSSE == 0) ? 8'd0 : 8'(MAX_POSSE - 1);

    estado_t    estado, prox_estado;
    logic [2:0] dono, prox_dono;
    logic [7:0] posse, prox_posse;
    logic [5:0] prox_conc;
    logic [3:0] prox_sel;
    logic       prox_val;

    logic       concede;
    logic [5:0] candidatos;
    logic [5:0] outros;
    logic [2:0] inicio;
    logic [2:0] vence;

    // First asserted bit of req, scanning upward from inicio with wrap at 6.
    function automatic logic [2:0] vencedor(input logic [5:0] req,
                                            input logic [2:0] ini);
        logic [2:0] w;
        logic       achou;
        logic [3:0] s;
        w     = 3'd0;
        achou = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s = {1'b0, ini} + 4'(k);
            if (s >= 4'd6) s = s - 4'd6;
            if (!achou && req[s[2:0]]) begin
                w     = s[2:0];
                achou = 1'b1;
            end
        end
        return w;
    endfunction

    // mux6_1 uses a sparse selector map.
    function automatic logic [3:0] codigo(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b0000;
            3'd1:    c = 4'b0001;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0111;
            3'd5:    c = 4'b1100;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    assign inicio = 3'd0;
`else
    logic [2:0] ponteiro;

    // Search begins just after the last granted index; reset value 5 makes
    // index 0 the first candidate.
    assign inicio = (ponteiro == 3'd5) ? 3'd0 : ponteiro + 3'd1;

    always_ff @(posedge clock) begin
        if (reset)        ponteiro <= 3'd5;
        else if (concede) ponteiro <= vence;
    end
`endif

    // The holder is masked out here, so a timeout or a release can never
    // hand the grant straight back to it.
    assign outros = requisicao & ~(6'b000001 << dono);
    assign vence  = vencedor(candidatos, inicio);

    always_comb begin
        prox_estado = estado;
        prox_dono   = dono;
        prox_posse  = posse;
        prox_conc   = concessao;
        prox_sel    = seletor;
        prox_val    = valido;
        concede     = 1'b0;
        candidatos  = 6'b0;

        case (estado)
            OCIOSO: begin
                if (requisicao != 6'b0) begin
                    concede    = 1'b1;
                    candidatos = requisicao;
                end
            end
            POSSE: begin
                if (!requisicao[dono]) begin
                    // Release wins over a coincident timeout; either way the
                    // next winner comes from the other requesters.
                    if (outros != 6'b0) begin
                        concede    = 1'b1;
                        candidatos = outros;
                    end else begin
                        prox_estado = OCIOSO;
                        prox_posse  = 8'd0;
                        prox_conc   = 6'b0;
                        prox_sel    = 4'b0000;
                        prox_val    = 1'b0;
                    end
                end else if (MAX_POSSE != 0 && posse == LIMITE && outros != 6'b0) begin
                    concede    = 1'b1;
                    candidatos = outros;
                end else if (MAX_POSSE != 0 && posse < LIMITE) begin
                    // Counts even while alone, so a late arrival can take
                    // over at once once the holder has saturated.
                    prox_posse = posse + 8'd1;
                end
            end
            default: prox_estado = OCIOSO;
        endcase

        if (concede) begin
            prox_estado = POSSE;
            prox_dono   = vence;
            prox_posse  = 8'd0;
            prox_conc   = 6'b000001 << vence;
            prox_sel    = codigo(vence);
            prox_val    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            dono      <= 3'd0;
            posse     <= 8'd0;
            concessao <= 6'b0;
            seletor   <= 4'b0000;
            valido    <= 1'b0;
        end else begin
            estado    <= prox_estado;
            dono      <= prox_dono;
            posse     <= prox_posse;
            concessao <= prox_conc;
            seletor   <= prox_sel;
            valido    <= prox_val;
        end
    end

endmodule

// File: tb/tb_arbitro_mux6.sv
module tb_arbitro_mux6;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] requisicao;

    logic [5:0] conc2, conc0, conc8;
    logic [3:0] sel2, sel0, sel8;
    logic       val2, val0, val8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    arbitro_mux6 #(.MAX_POSSE(2)) u2 (
        .clock(clock), .reset(reset), .requisicao(requisicao),
        .concessao(conc2), .seletor(sel2), .valido(val2));

    arbitro_mux6 #(.MAX_POSSE(0)) u0 (
        .clock(clock), .reset(reset), .requisicao(requisicao),
        .concessao(conc0), .seletor(sel0), .valido(val0));

    arbitro_mux6 #(.MAX_POSSE(8)) u8 (
        .clock(clock), .reset(reset), .requisicao(requisicao),
        .concessao(conc8), .seletor(sel8), .valido(val8));

    typedef struct {
        logic       rst;
        logic [5:0] req;
        logic [5:0] conc;
        logic [3:0] sel;
        logic       val;
    } vec_t;

    vec_t tab[22];

    function automatic logic [3:0] cod(input int idx);
        logic [3:0] t[6];
        t[0] = 4'b0000; t[1] = 4'b0001; t[2] = 4'b0010;
        t[3] = 4'b0110; t[4] = 4'b0111; t[5] = 4'b1100;
        return t[idx];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nome,
                       input logic [5:0] c, input logic [3:0] s, input logic v,
                       input logic [5:0] ec, input logic [3:0] es, input logic ev);
        n_chk++;
        if (c !== ec || s !== es || v !== ev) begin
            n_fail++;
            $display("FAIL %s: got conc=%b sel=%b val=%b, want conc=%b sel=%b val=%b",
                     nome, c, s, v, ec, es, ev);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; requisicao = 6'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        int idx;
        reset = 1'b1;
        requisicao = 6'b0;

        // Vectors checked against the MAX_POSSE=8 instance, one edge per row.
        tab[0]  = '{1'b1, 6'b000000, 6'b000000, 4'b0000, 1'b0};
        tab[1]  = '{1'b1, 6'b000000, 6'b000000, 4'b0000, 1'b0};
        for (int i = 2; i < 7; i++)
            tab[i] = '{1'b0, 6'b000000, 6'b000000, 4'b0000, 1'b0};
        tab[7]  = '{1'b0, 6'b001000, 6'b001000, 4'b0110, 1'b1};
        tab[8]  = '{1'b0, 6'b000000, 6'b000000, 4'b0000, 1'b0};
        tab[9]  = '{1'b0, 6'b000010, 6'b000010, 4'b0001, 1'b1};
        tab[10] = '{1'b0, 6'b100010, 6'b000010, 4'b0001, 1'b1};
        tab[11] = '{1'b0, 6'b100000, 6'b100000, 4'b1100, 1'b1};
        tab[12] = '{1'b0, 6'b100000, 6'b100000, 4'b1100, 1'b1};
        tab[13] = '{1'b0, 6'b000001, 6'b000001, 4'b0000, 1'b1};
        tab[14] = '{1'b0, 6'b010001, 6'b000001, 4'b0000, 1'b1};
        tab[15] = '{1'b0, 6'b010000, 6'b010000, 4'b0111, 1'b1};
        tab[16] = '{1'b0, 6'b000000, 6'b000000, 4'b0000, 1'b0};
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
        tab[17] = '{1'b0, 6'b111111, 6'b000001, 4'b0000, 1'b1};
`else
        tab[17] = '{1'b0, 6'b111111, 6'b100000, 4'b1100, 1'b1};
`endif
        tab[18] = '{1'b1, 6'b111111, 6'b000000, 4'b0000, 1'b0};
        tab[19] = '{1'b0, 6'b100010, 6'b000010, 4'b0001, 1'b1};
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
        tab[20] = '{1'b0, 6'b100001, 6'b000001, 4'b0000, 1'b1};
`else
        tab[20] = '{1'b0, 6'b100001, 6'b100000, 4'b1100, 1'b1};
`endif
        tab[21] = '{1'b0, 6'b000000, 6'b000000, 4'b0000, 1'b0};

        for (int i = 0; i < 22; i++) begin
            reset = tab[i].rst;
            requisicao = tab[i].req;
            tick();
            chk($sformatf("vec%0d", i), conc8, sel8, val8,
                tab[i].conc, tab[i].sel, tab[i].val);
        end

        // Rotation, MAX_POSSE=2, all six requesting: each holder keeps 2 cycles.
        do_reset();
        requisicao = 6'b111111;
        for (int k = 0; k < 13; k++) begin
            tick();
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
            idx = (k / 2) % 2;
`else
            idx = (k / 2) % 6;
`endif
            chk($sformatf("rot%0d", k), conc2, sel2, val2,
                6'b000001 << idx, cod(idx), 1'b1);
        end

        // Reset mid-grant clears everything on that edge.
        reset = 1'b1;
        tick();
        chk("rst_mid", conc2, sel2, val2, 6'b0, 4'b0000, 1'b0);
        reset = 1'b0;
        requisicao = 6'b0;
        tick();

        // Unlimited posse: holder 2 never loses the grant to waiting 4.
        do_reset();
        requisicao = 6'b000100;
        tick();
        chk("unl_grant", conc0, sel0, val0, 6'b000100, 4'b0010, 1'b1);
        requisicao = 6'b010100;
        for (int k = 0; k < 300; k++) begin
            tick();
            chk($sformatf("unl%0d", k), conc0, sel0, val0, 6'b000100, 4'b0010, 1'b1);
        end

        // Saturation with MAX_POSSE=8: lone holder 2 for 20 cycles, then 0 arrives.
        do_reset();
        requisicao = 6'b000100;
        tick();
        chk("sat_grant", conc8, sel8, val8, 6'b000100, 4'b0010, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("sat%0d", k), conc8, sel8, val8, 6'b000100, 4'b0010, 1'b1);
        end
        requisicao = 6'b000101;
        tick();
        chk("sat_take", conc8, sel8, val8, 6'b000001, 4'b0000, 1'b1);
        // Holder 0 gets exactly 8 cycles while 2 waits.
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("hold8_%0d", k), conc8, sel8, val8, 6'b000001, 4'b0000, 1'b1);
        end
        tick();
        chk("timeout8", conc8, sel8, val8, 6'b000100, 4'b0010, 1'b1);

        requisicao = 6'b0;
        tick();
        chk("final_idle", conc8, sel8, val8, 6'b0, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
